// File: rtl/sdf_fft_pkg.sv
// Shared constants and helpers for the 32-point SDF FFT sequencer.
//
// Contents:
//   LOG2N, N, S, TWA_W, GW  - FFT size, stage count, twiddle address width,
//                             global counter width
//   ST_IDLE/ST_LOAD/ST_FLUSH/ST_DONE - controller state encoding
//   stage_delay(s)          - delay-line length D_s of stage s
//   stage_offset(s)         - global count L_s at which stage s sees its
//                             first sample
//   bitrev(v)               - LOG2N-bit bit reversal
package sdf_fft_pkg;

  localparam int LOG2N = 5;
  localparam int N     = 1 << LOG2N;
  localparam int S     = LOG2N;
  localparam int TWA_W = LOG2N - 1;
  // One extra bit covers the flush (g up to 2N-1), one more keeps the
  // per-stage local count c_s = g - L_s representable as a signed value.
  localparam int GW    = LOG2N + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int stage_delay(input int s);
    return 1 << (LOG2N - 1 - s);
  endfunction

  function automatic int stage_offset(input int s);
    return N - (1 << (LOG2N - s));
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_fft_ctrl_if.sv
// Bundle between the SDF FFT sequencer and its surroundings (sample source,
// stage chain, output consumer).
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on controller state, never on
// in_valid, so the source may hold in_valid high indefinitely; in_valid is
// ignored whenever in_ready is 0.
//
// Signals:
//   in_valid  - source sample valid
//   in_ready  - controller accepts samples
//   adv       - global pipeline advance strobe
//   stage_act - per-stage live-data flag
//   bf_sel    - per-stage butterfly (1) / fill-rotate (0) select
//   tw_addr   - packed per-stage twiddle ROM address
//   out_valid - final stage output sample valid
//   out_idx   - frequency index of the output sample
//   busy      - frame in progress
//   done      - one-cycle end-of-frame pulse
//   fsm_state - controller state, for observation only
//
// Modports: master = controller, slave = everything around it.
interface sdf_fft_ctrl_if;
  import sdf_fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 adv;
  logic [S-1:0]         stage_act;
  logic [S-1:0]         bf_sel;
  logic [S*TWA_W-1:0]   tw_addr;
  logic                 out_valid;
  logic [LOG2N-1:0]     out_idx;
  logic                 busy;
  logic                 done;
  logic [1:0]           fsm_state;

  modport master (
    input  in_valid,
    output in_ready, adv, stage_act, bf_sel, tw_addr,
    output out_valid, out_idx, busy, done, fsm_state
  );

  modport slave (
    output in_valid,
    input  in_ready, adv, stage_act, bf_sel, tw_addr,
    input  out_valid, out_idx, busy, done, fsm_state
  );

endinterface

// File: rtl/sdf_stage_sched.sv
// Schedule decoder for one SDF butterfly stage.
// Maps the global counter to this stage's enable, butterfly select and
// twiddle address. Purely combinational.
//
// Ports:
//   g   in  GW     global counter
//   adv in  1      pipeline advance; all outputs are 0 when adv=0
//   act out 1      stage holds live data
//   bf  out 1      butterfly phase (1) / fill-rotate phase (0)
//   tw  out TWA_W  twiddle ROM address, (c mod D) << STAGE in the rotate phase
module sdf_stage_sched
  import sdf_fft_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic             g_bits_unused_guard_n, // tied high; keeps port list stable
  input  logic [GW-1:0]    g,
  input  logic             adv,
  output logic             act,
  output logic             bf,
  output logic [TWA_W-1:0] tw
);

  localparam int D = stage_delay(STAGE);
  localparam int L = stage_offset(STAGE);

  localparam logic signed [GW-1:0] L_C   = GW'(L);
  localparam logic signed [GW-1:0] D_C   = GW'(D);
  localparam logic signed [GW-1:0] LIM_C = GW'(N + D);
  localparam logic [TWA_W-1:0]     MASK  = TWA_W'(D - 1);

  // Local count: negative before the first sample reaches this stage.
  logic signed [GW-1:0] c;
  logic [TWA_W-1:0]     tw_raw;
  logic                 live;

  assign c      = $signed(g) - L_C;
  assign live   = g_bits_unused_guard_n & adv & ~c[GW-1] & (c < LIM_C);
  // For the last stage D=1, so MASK=0 and the address is always W^0.
  assign tw_raw = (TWA_W'(c) & MASK) << STAGE;

  assign act = live;
  assign bf  = live & c[LOG2N-1-STAGE];
  assign tw  = (live && !c[LOG2N-1-STAGE] && (c >= D_C)) ? tw_raw : '0;

endmodule

// File: rtl/sdf_fft_ctrl.sv
// Central sequencer for the 32-point single-path delay-feedback FFT.
// Accepts one frame of N samples, then flushes the stage chain, driving
// every stage's enable, butterfly select and twiddle address from a single
// global counter g. Frames never overlap: a new frame starts only from IDLE.
//
// Optional feature: define FFT_CTRL_BITREV_EN to report out_idx as the true
// (bit-reversed) frequency bin; otherwise out_idx is the natural output
// ordinal and a downstream reorder buffer owns the reversal.
//
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   bus   sdf_fft_ctrl_if.master (handshake, stage controls, output flags)
module sdf_fft_ctrl
  import sdf_fft_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sdf_fft_ctrl_if.master bus
);

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic [GW-1:0]      g;
  logic               adv_raw;
  logic               adv;
  logic [S-1:0]       act_v;
  logic [S-1:0]       bf_v;
  logic [S*TWA_W-1:0] tw_v;
  logic               out_valid;
  logic [LOG2N-1:0]   ord;

  // Next state and advance strobe. in_valid only matters while accepting.
  always_comb begin
    adv_raw  = 1'b0;
    state_nx = state;
    case (state)
      ST_IDLE: begin
        adv_raw = bus.in_valid;
        if (bus.in_valid) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        adv_raw = bus.in_valid;
        if (bus.in_valid && (g == GW'(N - 1))) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        adv_raw = 1'b1;
        if (g == GW'(2 * N - 2)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Gating with rst_n keeps adv (and everything derived from it) low while
  // reset is held, even if the source is presenting a sample.
  assign adv = adv_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      g     <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == ST_IDLE) begin
        g <= '0;
      end else if (adv) begin
        g <= g + GW'(1);
      end
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    sdf_stage_sched #(.STAGE(s)) u_sched (
      .g_bits_unused_guard_n (1'b1),
      .g                     (g),
      .adv                   (adv),
      .act                   (act_v[s]),
      .bf                    (bf_v[s]),
      .tw                    (tw_v[s*TWA_W +: TWA_W])
    );
  end

  // The last stage emits its first result N-1 advances after the first input.
  assign out_valid = adv & (g >= GW'(N - 1)) & (g <= GW'(2 * N - 2));
  assign ord       = LOG2N'(g - GW'(N - 1));

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign bus.adv       = adv;
  assign bus.stage_act = act_v;
  assign bus.bf_sel    = bf_v;
  assign bus.tw_addr   = tw_v;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state == ST_LOAD) || (state == ST_FLUSH);
  assign bus.done      = (state == ST_DONE);
  assign bus.fsm_state = state;

`ifdef FFT_CTRL_BITREV_EN
  assign bus.out_idx = out_valid ? bitrev(ord) : '0;
`else
  assign bus.out_idx = out_valid ? ord : '0;
`endif

endmodule

// File: tb/tb_sdf_fft_ctrl.sv
// Self-checking bench for sdf_fft_ctrl.
// The reference model tracks samples accepted and flush cycles taken, and
// derives every expected stage control from the stage offset/delay rules
// with plain integer arithmetic.
module tb_sdf_fft_ctrl;
  import sdf_fft_pkg::*;

  typedef struct packed {
    logic               ready;
    logic               adv;
    logic [S-1:0]       act;
    logic [S-1:0]       bf;
    logic [S*TWA_W-1:0] tw;
    logic               ov;
    logic [LOG2N-1:0]   idx;
    logic               busy;
    logic               done;
  } snap_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdf_fft_ctrl_if bus ();

  sdf_fft_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int               n_chk = 0;
  int               n_bad = 0;
  logic [LOG2N-1:0] exp_q[$];
  logic [LOG2N-1:0] exp_idx;
  snap_t            o;
  snap_t            e;

  // Model state: samples accepted, flush cycles taken, done cycle pending.
  int m_acc;
  int m_fl;
  bit m_done;

  // ---------------- reference model ----------------
  function automatic logic [LOG2N-1:0] ref_idx(input int ord);
`ifdef FFT_CTRL_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      if (((ord >> i) & 1) == 1) r += 1 << (LOG2N - 1 - i);
    end
    return LOG2N'(r);
`else
    return LOG2N'(ord);
`endif
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_fl   = 0;
    m_done = 1'b0;
  endtask

  task automatic model_expect(input logic v);
    int g;
    logic a;
    e = '0;
    g = 0;
    a = 1'b0;
    if (m_done) begin
      e.done = 1'b1;
    end else if (m_acc < N) begin
      e.ready = 1'b1;
      a       = v;
      g       = m_acc;
      e.busy  = (m_acc > 0);
    end else begin
      a      = 1'b1;
      g      = N + m_fl;
      e.busy = 1'b1;
    end
    e.adv = a;
    for (int s = 0; s < S; s++) begin
      int d;
      int l;
      int c;
      d = 1 << (LOG2N - 1 - s);
      l = N - (1 << (LOG2N - s));
      c = g - l;
      if (a && c >= 0 && c < N + d) begin
        e.act[s] = 1'b1;
        if (((c / d) % 2) == 1) e.bf[s] = 1'b1;
        else if (c >= d) e.tw[s*TWA_W +: TWA_W] = TWA_W'((c % d) << s);
      end
    end
    if (a && g >= N - 1 && g <= 2 * N - 2) begin
      e.ov  = 1'b1;
      e.idx = ref_idx(g - (N - 1));
    end
  endtask

  task automatic model_step(input logic v);
    if (m_done) begin
      model_reset();
    end else if (m_acc < N) begin
      if (v) m_acc++;
    end else begin
      m_fl++;
      if (m_fl == N - 1) m_done = 1'b1;
    end
  endtask

  task automatic sb_load_frame();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(ref_idx(i));
  endtask

  // ---------------- drivers ----------------
  task automatic sample();
    o.ready = bus.in_ready;
    o.adv   = bus.adv;
    o.act   = bus.stage_act;
    o.bf    = bus.bf_sel;
    o.tw    = bus.tw_addr;
    o.ov    = bus.out_valid;
    o.idx   = bus.out_idx;
    o.busy  = bus.busy;
    o.done  = bus.done;
  endtask

  // Called at posedge+1; drives in_valid, samples at negedge, steps the model.
  task automatic drive_cycle(input logic v);
    bus.in_valid = v;
    @(negedge clk);
    sample();
    model_expect(v);
    @(posedge clk);
    #1;
    model_step(v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    e       = '0;
    e.ready = 1'b1;
    n_chk++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_outs got=%h want=%h", o, e);
    end
    n_chk++;
    if (bus.fsm_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_state got=%0d want=%0d", bus.fsm_state, ST_IDLE);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    model_reset();
    drive_cycle(1'b0);
    n_chk++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_idle got=%h want=%h", o, e);
    end
  endtask

  task automatic test_contiguous_frame();
    int adv_n     = 0;
    int n_out     = 0;
    int n_done    = 0;
    int first_out = -1;
    int ready_low = -1;
    int done_at   = -1;
    sb_load_frame();
    for (int i = 0; i < 70; i++) begin
      drive_cycle(logic'(i < N));
      n_chk++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL contig cyc=%0d got=%h want=%h", i, o, e);
      end
      if (o.ov === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL contig_sb extra idx got=%0d want=none", o.idx);
        end else begin
          exp_idx = exp_q.pop_front();
          if (o.idx !== exp_idx) begin
            n_bad++;
            $display("FAIL contig_sb idx got=%0d want=%0d", o.idx, exp_idx);
          end
        end
        if (first_out < 0) first_out = adv_n;
        n_out++;
      end
      if (o.ready === 1'b0 && ready_low < 0) ready_low = adv_n;
      if (o.done === 1'b1) begin
        n_done++;
        done_at = adv_n;
      end
      if (o.adv === 1'b1) adv_n++;
    end
    n_chk++;
    if (ready_low != N) begin
      n_bad++;
      $display("FAIL contig_ready_fall got=%0d want=%0d", ready_low, N);
    end
    n_chk++;
    if (n_out != N || first_out != N - 1) begin
      n_bad++;
      $display("FAIL contig_out_window got=%0d@%0d want=%0d@%0d", n_out, first_out, N, N - 1);
    end
    n_chk++;
    if (n_done != 1 || done_at != 2 * N - 1) begin
      n_bad++;
      $display("FAIL contig_done got=%0d@%0d want=1@%0d", n_done, done_at, 2 * N - 1);
    end
    n_chk++;
    if (o.ready !== 1'b1 || o.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL contig_idle got=%b%b want=10", o.ready, o.busy);
    end
  endtask

  task automatic test_stage_schedule();
    int g = 0;
    for (int i = 0; i < 2 * N; i++) begin
      drive_cycle(logic'(i < N));
      if (o.adv === 1'b1) begin
        if (g < N) begin
          n_chk++;
          if (o.bf[0] !== logic'(g >= N / 2)) begin
            n_bad++;
            $display("FAIL sched_bf0 g=%0d got=%b want=%b", g, o.bf[0], g >= N / 2);
          end
        end
        if (g >= N && g < N + N / 2) begin
          n_chk++;
          if (o.tw[TWA_W-1:0] !== TWA_W'(g - N)) begin
            n_bad++;
            $display("FAIL sched_tw0 g=%0d got=%0d want=%0d", g, o.tw[TWA_W-1:0], g - N);
          end
        end
        if (g >= N && g < N + N / 4) begin
          n_chk++;
          if (o.tw[2*TWA_W-1:TWA_W] !== TWA_W'(2 * (g - N))) begin
            n_bad++;
            $display("FAIL sched_tw1 g=%0d got=%0d want=%0d", g, o.tw[2*TWA_W-1:TWA_W], 2 * (g - N));
          end
        end
        g++;
      end
      if (i == 2 * N - 1) begin
        n_chk++;
        if (o.done !== 1'b1) begin
          n_bad++;
          $display("FAIL sched_done got=%b want=1", o.done);
        end
      end
    end
  endtask

  task automatic test_stall();
    int stall_left = 5;
    int cyc        = 0;
    int n_done     = 0;
    logic v;
    sb_load_frame();
    while (n_done == 0 && cyc < 120) begin
      v = logic'(!(m_acc == 10 && stall_left > 0));
      drive_cycle(v);
      n_chk++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL stall cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (!v) begin
        stall_left--;
        n_chk++;
        if (o.adv !== 1'b0 || o.act !== '0 || o.bf !== '0 || o.tw !== '0 || o.ready !== 1'b1) begin
          n_bad++;
          $display("FAIL stall_hold cyc=%0d got=%h want=adv/act/bf/tw zero, ready=1", cyc, o);
        end
      end
      if (o.ov === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stall_sb extra idx got=%0d want=none", o.idx);
        end else begin
          exp_idx = exp_q.pop_front();
          if (o.idx !== exp_idx) begin
            n_bad++;
            $display("FAIL stall_sb idx got=%0d want=%0d", o.idx, exp_idx);
          end
        end
      end
      if (o.done === 1'b1) n_done++;
      cyc++;
    end
    n_chk++;
    if (cyc != 2 * N - 1 + 5 + 1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stall_len got=%0d/%0d want=%0d/0", cyc, exp_q.size(), 2 * N + 5);
    end
  endtask

  task automatic test_flush_valid();
    int flush_n = 0;
    int cyc     = 0;
    bit seen    = 1'b0;
    while (!seen && cyc < 120) begin
      drive_cycle(1'b1);
      n_chk++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL flushv cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o.adv === 1'b1 && o.ready === 1'b0) flush_n++;
      if (o.done === 1'b1) seen = 1'b1;
      cyc++;
    end
    n_chk++;
    if (flush_n != N - 1 || !seen) begin
      n_bad++;
      $display("FAIL flushv_len got=%0d done=%b want=%0d done=1", flush_n, seen, N - 1);
    end
    drive_cycle(1'b0);
    n_chk++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL flushv_idle got=%h want=%h", o, e);
    end
  endtask

  task automatic test_bitrev();
    logic [LOG2N-1:0] want [5];
    logic [LOG2N-1:0] got [5];
    int n_got = 0;
`ifdef FFT_CTRL_BITREV_EN
    want = '{5'd0, 5'd16, 5'd8, 5'd24, 5'd4};
`else
    want = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
`endif
    for (int i = 0; i < 2 * N; i++) begin
      drive_cycle(logic'(i < N));
      if (o.ov === 1'b1 && n_got < 5) begin
        got[n_got] = o.idx;
        n_got++;
      end
    end
    n_chk++;
    if (n_got != 5) begin
      n_bad++;
      $display("FAIL bitrev_count got=%0d want=5", n_got);
    end
    for (int k = 0; k < n_got; k++) begin
      n_chk++;
      if (got[k] !== want[k]) begin
        n_bad++;
        $display("FAIL bitrev_idx out=%0d got=%0d want=%0d", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int cyc    = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1);
      if (o.done === 1'b1) n_done++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    sample();
    e       = '0;
    e.ready = 1'b1;
    n_chk++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL rstmid_async got=%h want=%h", o, e);
    end
    repeat (2) begin
      @(negedge clk);
      sample();
      n_chk++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rstmid_hold got=%h want=%h", o, e);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb_load_frame();
    while (n_done == 0 && cyc < 100) begin
      drive_cycle(1'b1);
      n_chk++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rstmid_frame cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o.ov === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rstmid_sb extra idx got=%0d want=none", o.idx);
        end else begin
          exp_idx = exp_q.pop_front();
          if (o.idx !== exp_idx) begin
            n_bad++;
            $display("FAIL rstmid_sb idx got=%0d want=%0d", o.idx, exp_idx);
          end
        end
      end
      if (o.done === 1'b1) n_done++;
      cyc++;
    end
    n_chk++;
    if (n_done != 1 || cyc != 2 * N) begin
      n_bad++;
      $display("FAIL rstmid_len done=%0d cyc=%0d want done=1 cyc=%0d", n_done, cyc, 2 * N);
    end
    bus.in_valid = 1'b0;
    drive_cycle(1'b0);
  endtask

  task automatic test_random_frames();
    logic v;
    for (int f = 0; f < 4; f++) begin
      int n_done = 0;
      int cyc    = 0;
      int gap;
      sb_load_frame();
      while (n_done == 0 && cyc < 300) begin
        v = logic'($urandom_range(0, 99) < 70);
        drive_cycle(v);
        n_chk++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL rand f=%0d cyc=%0d got=%h want=%h", f, cyc, o, e);
        end
        if (o.ov === 1'b1) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rand_sb extra idx got=%0d want=none", o.idx);
          end else begin
            exp_idx = exp_q.pop_front();
            if (o.idx !== exp_idx) begin
              n_bad++;
              $display("FAIL rand_sb idx got=%0d want=%0d", o.idx, exp_idx);
            end
          end
        end
        if (o.done === 1'b1) n_done++;
        cyc++;
      end
      n_chk++;
      if (n_done != 1 || exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL rand_end f=%0d done=%0d left=%0d want done=1 left=0", f, n_done, exp_q.size());
      end
      // Gap of zero starts the next frame on the first IDLE cycle.
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        drive_cycle(1'b0);
        n_chk++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL rand_gap got=%h want=%h", o, e);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid = 1'b0;
    model_reset();
    test_reset();
    test_contiguous_frame();
    test_stage_schedule();
    test_stall();
    test_flush_valid();
    test_bitrev();
    test_reset_mid();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
